// File: rtl/lcd_region_sched.sv
// Round-robin scheduler that lends one frame-memory address generator to NREQ
// requesters, streaming each winner's [begin, end) region under valid/ready.
module lcd_region_sched #(
    parameter int ADDR_WIDTH = 17,
    parameter int NREQ       = 3
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ*ADDR_WIDTH-1:0]   req_begin,
    input  logic [NREQ*ADDR_WIDTH-1:0]   req_end,
    output logic [NREQ-1:0]              grant,
    output logic [NREQ-1:0]              done,
    output logic                         busy,
    output logic                         addr_valid,
    output logic [ADDR_WIDTH-1:0]        addr,
    input  logic                         addr_ready
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [NREQ-1:0]       grant_q, grant_d;
    logic [NREQ-1:0]       mask_q, mask_d;
    logic [IW-1:0]         owner_q, owner_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] end_q, end_d;
    logic                  empty_q, empty_d;

    logic [NREQ-1:0]       req_eff;
    logic                  win_found;
    logic [IW-1:0]         win_idx;
    logic [ADDR_WIDTH-1:0] win_begin;
    logic [ADDR_WIDTH-1:0] win_end;
    logic [ADDR_WIDTH-1:0] last_addr;

    // The requester that just finished is masked only for the first IDLE cycle after DONE.
    always_comb begin
        req_eff   = req & ~mask_q;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!win_found && req_eff[(int'(ptr_q) + i) % NREQ]) begin
                win_found = 1'b1;
                win_idx   = IW'((int'(ptr_q) + i) % NREQ);
            end
        end
        win_begin = req_begin[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        win_end   = req_end[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        last_addr = end_q - ADDR_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            mask_q  <= '0;
            owner_q <= '0;
            ptr_q   <= IW'(NREQ - 1);
            cnt_q   <= '0;
            end_q   <= '0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            mask_q  <= mask_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            end_q   <= end_d;
            empty_q <= empty_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        mask_d  = '0;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        end_d   = end_q;
        empty_d = empty_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_RUN;
                    grant_d = NREQ'(1) << win_idx;
                    owner_d = win_idx;
                    cnt_d   = win_begin;
                    end_d   = win_end;
                    empty_d = (win_end <= win_begin);
                end
            end
            S_RUN: begin
                // A dropped request abandons the burst silently; ptr still advances.
                if ((req & grant_q) == '0) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    ptr_d   = owner_q;
                end else if (empty_q) begin
                    state_d = S_DONE;
                end else if (addr_ready) begin
                    if (cnt_q == last_addr) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + ADDR_WIDTH'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = '0;
                ptr_d   = owner_q;
                mask_d  = grant_q;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        grant      = grant_q;
        busy       = (state_q != S_IDLE);
        addr_valid = (state_q == S_RUN) && !empty_q;
        addr       = (state_q == S_RUN) ? cnt_q : '0;
        done       = (state_q == S_DONE) ? grant_q : '0;
    end

endmodule

// File: tb/tb_lcd_region_sched.sv
// Directed bench for lcd_region_sched: one task per scenario, inline checks, one summary line.
module tb_lcd_region_sched;

  localparam int AW = 17;
  localparam int NR = 3;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NR-1:0]     req;
  logic [NR*AW-1:0]  req_begin;
  logic [NR*AW-1:0]  req_end;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     done;
  logic              busy;
  logic              addr_valid;
  logic [AW-1:0]     addr;
  logic              addr_ready;

  int n_checks = 0;
  int n_pass   = 0;

  logic [AW-1:0] exp_q[$];

  lcd_region_sched #(.ADDR_WIDTH(AW), .NREQ(NR)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req        (req),
    .req_begin  (req_begin),
    .req_end    (req_end),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .addr_valid (addr_valid),
    .addr       (addr),
    .addr_ready (addr_ready)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic set_region(input int i, input int b, input int e);
    req_begin[i*AW +: AW] = AW'(b);
    req_end[i*AW +: AW]   = AW'(e);
  endtask

  task automatic test_reset();
    rstn = 1'b0; req = '0; addr_ready = 1'b0; req_begin = '0; req_end = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (grant !== 3'b000) $display("FAIL reset_grant got=%b exp=000", grant); else n_pass++;
    n_checks++; if (done !== 3'b000) $display("FAIL reset_done got=%b exp=000", done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (addr_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", addr_valid); else n_pass++;
    n_checks++; if (addr !== '0) $display("FAIL reset_addr got=%0d exp=0", addr); else n_pass++;
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_g [4];
    int            exp_b [4];
    logic [NR-1:0] prev_g;
    logic [NR-1:0] pend;
    int            gi;
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
    exp_b[0] = 32;     exp_b[1] = 40;     exp_b[2] = 48;     exp_b[3] = 32;
    set_region(0, 32, 34); set_region(1, 40, 42); set_region(2, 48, 50);
    prev_g = '0; pend = '0; gi = 0;
    addr_ready = 1'b1;
    req = 3'b111;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (grant !== prev_g && grant !== '0) begin
        if (gi < 4) begin
          n_checks++; if (grant !== exp_g[gi]) $display("FAIL rr_grant%0d got=%b exp=%b", gi, grant, exp_g[gi]); else n_pass++;
          n_checks++; if (addr !== AW'(exp_b[gi])) $display("FAIL rr_first_addr%0d got=%0d exp=%0d", gi, addr, exp_b[gi]); else n_pass++;
        end
        gi++;
      end
      prev_g = grant;
      if (done !== '0) begin
        req  = req & ~done;
        pend = done;
        if (gi == 4) begin
          req = '0;
          break;
        end
      end else if (!busy && pend != '0) begin
        req  = req | pend;
        pend = '0;
      end
    end
    n_checks++; if (gi != 4) $display("FAIL rr_grant_count got=%0d exp=4", gi); else n_pass++;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_single_burst();
    set_region(0, 16, 20);
    addr_ready = 1'b1;
    req = 3'b001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++; if (addr_valid !== 1'b1 || addr !== AW'(16 + k)) $display("FAIL single_addr%0d got=%0d/v%b exp=%0d/v1", k, addr, addr_valid, 16 + k); else n_pass++;
      n_checks++; if (grant !== 3'b001) $display("FAIL single_grant%0d got=%b exp=001", k, grant); else n_pass++;
    end
    @(negedge clk);
    n_checks++; if (done !== 3'b001) $display("FAIL single_done got=%b exp=001", done); else n_pass++;
    n_checks++; if (grant !== 3'b001 || addr_valid !== 1'b0) $display("FAIL single_done_cycle got=%b/v%b exp=001/v0", grant, addr_valid); else n_pass++;
    req = '0;
    @(negedge clk);
    n_checks++; if (grant !== 3'b000 || done !== 3'b000 || busy !== 1'b0) $display("FAIL single_idle got=%b/%b/%b exp=000/000/0", grant, done, busy); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int last_acc;
    bit got_done;
    set_region(0, 16, 20);
    exp_q.delete();
    for (int a = 16; a < 20; a++) exp_q.push_back(AW'(a));
    last_acc = -1; got_done = 1'b0;
    addr_ready = 1'b0;
    req = 3'b001;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done !== '0) begin
        got_done = 1'b1;
        n_checks++; if (done !== 3'b001) $display("FAIL bp_done got=%b exp=001", done); else n_pass++;
        n_checks++; if (cyc != last_acc + 1) $display("FAIL bp_done_timing got=cyc%0d exp=cyc%0d", cyc, last_acc + 1); else n_pass++;
        n_checks++; if (addr_valid !== 1'b0) $display("FAIL bp_done_valid got=%b exp=0", addr_valid); else n_pass++;
        break;
      end
      addr_ready = ((cyc % 2) == 1);
      if (addr_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL bp_extra_addr got=%0d exp=none", addr);
        else if (addr !== exp_q[0]) $display("FAIL bp_addr got=%0d exp=%0d", addr, exp_q[0]);
        else n_pass++;
        if (addr_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          last_acc = cyc;
        end
      end
    end
    n_checks++; if (!got_done) $display("FAIL bp_timeout got=no_done exp=done"); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL bp_missing got=%0d_left exp=0_left", exp_q.size()); else n_pass++;
    req = '0;
    addr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_empty_region();
    set_region(1, 5, 5);
    req = 3'b010;
    @(negedge clk);
    n_checks++; if (grant !== 3'b010 || busy !== 1'b1) $display("FAIL empty_grant got=%b/%b exp=010/1", grant, busy); else n_pass++;
    n_checks++; if (addr_valid !== 1'b0) $display("FAIL empty_run_valid got=%b exp=0", addr_valid); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 3'b010) $display("FAIL empty_done got=%b exp=010", done); else n_pass++;
    n_checks++; if (addr_valid !== 1'b0) $display("FAIL empty_done_valid got=%b exp=0", addr_valid); else n_pass++;
    req = '0;
    @(negedge clk);
    n_checks++; if (grant !== 3'b000 || done !== 3'b000) $display("FAIL empty_idle got=%b/%b exp=000/000", grant, done); else n_pass++;
  endtask

  task automatic test_mask();
    @(negedge clk);
    set_region(1, 7, 8);
    addr_ready = 1'b1;
    req = 3'b010;
    @(negedge clk);
    n_checks++; if (grant !== 3'b010 || addr !== AW'(7)) $display("FAIL mask_first got=%b/%0d exp=010/7", grant, addr); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 3'b010) $display("FAIL mask_done got=%b exp=010", done); else n_pass++;
    req = '0;
    @(negedge clk);
    req = 3'b010;
    @(negedge clk);
    n_checks++; if (grant !== 3'b000 || busy !== 1'b0) $display("FAIL mask_blocked got=%b/%b exp=000/0", grant, busy); else n_pass++;
    @(negedge clk);
    n_checks++; if (grant !== 3'b010 || addr !== AW'(7)) $display("FAIL mask_regrant got=%b/%0d exp=010/7", grant, addr); else n_pass++;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_abort();
    set_region(2, 0, 100);
    set_region(0, 200, 203);
    addr_ready = 1'b1;
    req = 3'b100;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++; if (grant !== 3'b100 || addr_valid !== 1'b1 || addr !== AW'(k)) $display("FAIL abort_addr%0d got=%b/v%b/%0d exp=100/v1/%0d", k, grant, addr_valid, addr, k); else n_pass++;
    end
    @(negedge clk);
    req = 3'b001;
    addr_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (grant !== 3'b000 || busy !== 1'b0) $display("FAIL abort_idle got=%b/%b exp=000/0", grant, busy); else n_pass++;
    n_checks++; if (done !== 3'b000) $display("FAIL abort_no_done got=%b exp=000", done); else n_pass++;
    addr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (grant !== 3'b001 || addr !== AW'(200 + k)) $display("FAIL abort_next_addr%0d got=%b/%0d exp=001/%0d", k, grant, addr, 200 + k); else n_pass++;
      n_checks++; if (done !== 3'b000) $display("FAIL abort_next_early_done%0d got=%b exp=000", k, done); else n_pass++;
    end
    @(negedge clk);
    n_checks++; if (done !== 3'b001) $display("FAIL abort_next_done got=%b exp=001", done); else n_pass++;
    req = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    set_region(1, 0, 50);
    addr_ready = 1'b1;
    req = 3'b010;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b1 || addr !== AW'(2)) $display("FAIL rst_pre_busy got=%b/%0d exp=1/2", busy, addr); else n_pass++;
    rstn = 1'b0;
    #1;
    n_checks++; if (grant !== 3'b000 || done !== 3'b000) $display("FAIL rst_mid_grant got=%b/%b exp=000/000", grant, done); else n_pass++;
    n_checks++; if (busy !== 1'b0 || addr_valid !== 1'b0 || addr !== '0) $display("FAIL rst_mid_outs got=%b/%b/%0d exp=0/0/0", busy, addr_valid, addr); else n_pass++;
    req = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    set_region(0, 300, 302); set_region(2, 400, 402);
    req = 3'b111;
    @(negedge clk);
    n_checks++; if (grant !== 3'b001 || addr !== AW'(300)) $display("FAIL rst_first_winner got=%b/%0d exp=001/300", grant, addr); else n_pass++;
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_burst();
    test_backpressure();
    test_empty_region();
    test_mask();
    test_abort();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_region_sched.md
# lcd_region_sched

Scheduler in front of the LCD frame-memory address path. It shares one address generator between NREQ requesters: a round-robin arbiter picks a requester, then streams that requester's region, addresses begin through end-1, to the LCD pixel fetch under a valid/ready handshake, and pulses done on completion. Requesters are, for example, the power-up initial fill, background redraw and sprite blit. It sits between those engines and the frame-memory read port.

## Interface
- ADDR_WIDTH, 17, address width.
- NREQ, 3, number of requesters (2..8).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- req  in  NREQ  per-requester level request; hold high until done.
- req_begin  in  NREQ*ADDR_WIDTH  packed region start; slice i is bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_end  in  NREQ*ADDR_WIDTH  packed region end, exclusive; same slicing as req_begin.
- grant  out  NREQ  one-hot owner of the address path; all zeros when idle.
- done  out  NREQ  one-cycle completion pulse to the owner.
- busy  out  1  high in RUN and DONE.
- addr_valid  out  1  addr holds a valid fetch address.
- addr  out  ADDR_WIDTH  current fetch address.
- addr_ready  in  1  downstream accepts addr this cycle.

## Operation
- States are IDLE, RUN and DONE.
- IDLE:
  - If any unmasked req is high, pick the winner round-robin. Search starts at index ptr+1 and wraps, where ptr is the last granted index; ptr resets to NREQ-1, so index 0 wins first.
  - Register the winner's begin into cnt and its end into end_r. Set grant to the winner's one-hot. Go to RUN.
  - With no request, stay in IDLE; all outputs hold their idle values.
- RUN:
  - addr = cnt and addr_valid = 1.
  - On addr_valid & addr_ready: if cnt == end_r-1, go to DONE; otherwise cnt <= cnt+1.
  - Without addr_ready, cnt and addr hold.
- Empty region: if end <= begin at grant, RUN lasts exactly one cycle with addr_valid=0, then the block goes to DONE. No address is issued.
- DONE (one cycle):
  - done[owner] = 1, grant[owner] stays 1, addr_valid = 0.
  - ptr <= owner. Next state is IDLE with grant cleared.
  - The just-finished requester's req is masked for the single IDLE cycle after DONE; the requester must drop req by then.
- Abort: if req[owner] falls during RUN, go to IDLE on the next edge.
  - No done pulse is issued.
  - ptr is still updated to the owner.
  - No mask applies, because the requester has already dropped req.
- Arithmetic:
  - All compares are unsigned ADDR_WIDTH.
  - end_r-1 is computed only when end_r > begin.
  - cnt never wraps: the last issued address is end_r-1 <= 2^ADDR_WIDTH-2.
- req_begin and req_end are sampled only at grant; later changes are ignored until the next grant.
- Reset values:
  - state = IDLE, grant = 0, done = 0, busy = 0, addr_valid = 0.
  - addr = 0, cnt = 0, end_r = 0, ptr = NREQ-1.
- Reset mid-RUN drops the burst immediately, with no done pulse.

## Timing
- grant, addr and addr_valid are registered state, or decoded only from registered state.
- Grant latency: req rises before edge t while IDLE, so grant and addr_valid are high from t; the first addr is begin.
- Throughput: one address per cycle while addr_ready=1. N addresses with no stalls take N RUN cycles plus 1 DONE cycle.
- Re-arbitration: one IDLE cycle between DONE and the next grant. Back-to-back bursts therefore have a 2-cycle gap (DONE + IDLE) in addr_valid.
- addr_ready is ignored whenever addr_valid=0.
- Simultaneous requests are resolved in the same IDLE cycle by round-robin order only. There is no preemption during RUN.

## Test plan
- Single burst: req[0] with begin=16, end=20, addr_ready tied 1.
  - addr_valid for 4 cycles, addr 16,17,18,19.
  - done[0] the next cycle; grant=0 after that.
- Backpressure: same region, addr_ready low on every other cycle.
  - Each address is held until accepted; no address is skipped or duplicated.
  - done[0] after addr 19 is accepted.
- Round-robin: req=3'b111 held, all regions 2 words long. Grant order is 0,1,2,0.
  - Requesters re-raise req after their done.
  - The finished requester is never re-granted in the masked IDLE cycle.
- Empty region: req[1] with begin=5, end=5.
  - No addr_valid.
  - done[1] one cycle after the RUN cycle.
- Abort: req[2] with begin=0, end=100; drop req[2] after 10 accepts.
  - Block returns to IDLE with no done pulse.
  - A pending req[0] is granted, with its first addr = req[0]'s begin.
- Reset mid-RUN: assert rstn low during a burst.
  - All outputs zero immediately, state IDLE.
  - After release, index 0 wins first among simultaneous requests.
